key_conditioner: RTL
====================

Name: key_conditioner

Overview:
Conditions the raw push-button inputs of the calculator into clean per-key events for the memory and operation logic downstream. For each key it synchronises, debounces, and normalises the key to active-high. It emits a debounced level, press/release/tap pulses, and a long-hold pulse. It sits between the board KEY pins and the memory/save-clear logic, so downstream blocks never count raw bounce.

Parameters:
NUM_KEYS, 2, number of independent keys conditioned (bit i = key i)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); must be >= 2
HOLD_CYCLES, 500000000, cycles of continuous debounced press before key_hold fires (10 s at 50 MHz); must be > DEBOUNCE_CYCLES
KEY_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
key_raw  input  NUM_KEYS  raw asynchronous button pins
key_level  output  NUM_KEYS  debounced pressed state, active-high
key_press  output  NUM_KEYS  1-cycle pulse when key_level rises
key_release  output  NUM_KEYS  1-cycle pulse when key_level falls
key_tap  output  NUM_KEYS  1-cycle pulse on release if key_hold did not fire during that press
key_hold  output  NUM_KEYS  1-cycle pulse when press duration reaches HOLD_CYCLES
hold_active  output  NUM_KEYS  level, high from key_hold pulse until release

Behaviour:
- Reset (reset=0, async): sync flops load the released value; stable state = released; debounce and hold counters = 0. All outputs = 0. Raw activity during reset is ignored.
- Per key, fully independent; no interaction between keys.
- Normalise: pressed = key_raw XOR KEY_ACTIVE_LOW. Pass through a 2-flop synchroniser; s2 is the synchronised sample.
- Debounce counter width = $clog2(DEBOUNCE_CYCLES)+1.
- Debounce counter rules:
  - If s2 == key_level, counter clears to 0.
  - If s2 != key_level, counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while s2 still differs, key_level toggles at the next edge and the counter clears.
  - A single-cycle glitch of s2 therefore restarts acceptance.
- Latency: a clean raw edge shows on key_level exactly 2+DEBOUNCE_CYCLES rising edges later.
- key_press and key_release are registered and assert in the same cycle key_level changes. They are never both high.
- Hold counter:
  - Width = $clog2(HOLD_CYCLES)+1.
  - Clears while key_level=0.
  - Increments each cycle key_level=1, saturating at HOLD_CYCLES.
  - key_hold pulses for exactly one cycle when the counter transitions HOLD_CYCLES-1 -> HOLD_CYCLES, i.e. HOLD_CYCLES cycles after the key_press cycle.
  - key_hold fires only once per press; saturation prevents wrap and re-fire.
- hold_active sets together with key_hold and clears together with key_release.
- Release outcome:
  - If hold_active=0 at release, key_tap pulses in the same cycle as key_release.
  - If hold_active=1 at release, key_tap stays 0.
- Release on the exact cycle key_hold would fire: the release wins. key_hold does not fire and key_tap pulses.
- Reset mid-press: all state clears. A key still held after reset deasserts is re-debounced and generates a fresh key_press.
- Counters must not overflow for any parameter values within the stated limits.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, NUM_KEYS=2, KEY_ACTIVE_LOW=1.
- key_raw[0] 1->0 held clean -> key_level[0] and key_press[0] rise 6 edges later. key_press is high 1 cycle. Key 1 outputs stay 0.
- key_raw[0] bounces 0/1 every 2 cycles for 12 cycles, then holds 0 -> exactly one key_press[0]. It occurs 6 edges after the final transition.
- Press key 0 for 10 cycles after key_press, then release -> key_release[0] and key_tap[0] pulse together. key_hold[0] and hold_active[0] never assert.
- Press key 1 and hold 40 cycles -> key_hold[1] pulses once 20 cycles after key_press[1]. hold_active[1] stays high until release. On release, key_release[1]=1 and key_tap[1]=0.
- Both keys pressed in the same cycle -> simultaneous key_press[1:0]=2'b11 with independent hold timing.
- Assert reset while key 0 is held at hold count 15 -> all outputs 0 immediately (async). After reset deasserts with key still held, a new key_press[0] occurs 6 edges later and key_hold[0] follows 20 cycles after that.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Raw key pins in, conditioned per-key events out; bit i of every vector belongs to key i.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_tap;
    logic [NUM_KEYS-1:0] key_hold;
    logic [NUM_KEYS-1:0] hold_active;

    // master: the conditioner itself; slave: board pins plus downstream consumers
    modport master (
        input  key_raw,
        output key_level, key_press, key_release, key_tap, key_hold, hold_active
    );

    modport slave (
        output key_raw,
        input  key_level, key_press, key_release, key_tap, key_hold, hold_active
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and press/release/tap/hold event generator.
// Keys are fully independent; all outputs are registered.
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 500000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    key_conditioner_if.master kif
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] level_q, press_q, release_q, tap_q, hold_q, hold_active_q;
    logic [DEB_W-1:0]    deb_cnt_q  [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_cnt_q [NUM_KEYS];

    logic [NUM_KEYS-1:0] toggle;
    logic [NUM_KEYS-1:0] hold_hit;

    assign pressed = kif.key_raw ^ {NUM_KEYS{KEY_ACTIVE_LOW}};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        toggle   = '0;
        hold_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            toggle[i]   = (sync2_q[i] != level_q[i]) && (deb_cnt_q[i] == DEB_LAST);
            // A release landing on the hold cycle suppresses the hold.
            hold_hit[i] = level_q[i] && (hold_cnt_q[i] == HOLD_LAST)
                          && !(toggle[i] && level_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the synchroniser resets to "released" so pin activity during reset cannot become a press.
            sync1_q       <= '0;
            sync2_q       <= '0;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            tap_q         <= '0;
            hold_q        <= '0;
            hold_active_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so sync2_q sees last cycle's sync1_q, not this one's.
            sync1_q <= pressed;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (toggle[i]) begin
                    deb_cnt_q[i] <= '0;
                    level_q[i]   <= ~level_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DEB_ONE;
                end

                press_q[i]   <= toggle[i] && !level_q[i];
                release_q[i] <= toggle[i] && level_q[i];
                tap_q[i]     <= toggle[i] && level_q[i] && !hold_active_q[i];
                hold_q[i]    <= hold_hit[i];

                // Saturating at HOLD_CYCLES keeps key_hold to one pulse per press.
                if (!level_q[i]) begin
                    hold_cnt_q[i] <= '0;
                end else if (hold_cnt_q[i] != HOLD_MAX) begin
                    hold_cnt_q[i] <= hold_cnt_q[i] + HOLD_ONE;
                end

                if (hold_hit[i]) begin
                    hold_active_q[i] <= 1'b1;
                end else if (toggle[i] && level_q[i]) begin
                    hold_active_q[i] <= 1'b0;
                end
            end
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_tap     = tap_q;
    assign kif.key_hold    = hold_q;
    assign kif.hold_active = hold_active_q;

endmodule
